debounce_repeat_array: RTL
==========================

DEBOUNCE_REPEAT_ARRAY -- requirements
Module: debounce_repeat_array

Interface
REQ-001 The block SHALL expose parameter N, default 4: number of independent button channels (1..16).
REQ-002 The block SHALL expose parameter DEBOUNCE_CYCLES, default 1000000: stable-sample count for press or release qualification (>=2).
REQ-003 The block SHALL expose parameter REPEAT_DELAY, default 30000000: cycles from press pulse to first auto-repeat pulse (>=2).
REQ-004 The block SHALL expose parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses (>=2).
REQ-005 The block SHALL expose parameter REPEAT_MASK, default all-ones, N bits: bit i=1 enables auto-repeat on channel i.
REQ-006 Port clk, input, 1: single clock for all logic.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port noisy, input, N: raw asynchronous button levels, active-high.
REQ-009 Port debounced, output, N: qualified level per channel.
REQ-010 Port press, output, N: one-cycle pulse per qualified press.
REQ-011 Port release, output, N: one-cycle pulse per qualified release.
REQ-012 Port action, output, N: press OR auto-repeat pulse, one cycle each.

Function
REQ-013 Each noisy bit SHALL pass through a 2-flop synchronizer; s[i] denotes the second flop; channels SHALL be fully independent.
REQ-014 Each channel SHALL run a 4-state FSM, IDLE, ARMING, PRESSED, RELEASING, with an internal debounce counter cnt sized ceil(log2(max parameter+1)).
REQ-015 IDLE: s=1 -> ARMING, cnt<=0; otherwise stay.
REQ-016 ARMING: s=0 -> IDLE, cnt<=0; s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt<=0; otherwise cnt+1.
REQ-017 PRESSED: s=0 -> RELEASING, cnt<=0; otherwise stay.
REQ-018 RELEASING: s=1 -> PRESSED, cnt<=0, with no press pulse; s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0; otherwise cnt+1.
REQ-019 debounced[i] SHALL be 1 exactly while the state is PRESSED or RELEASING.
REQ-020 press[i] SHALL be 1 only in the first cycle of PRESSED entered from ARMING.
REQ-021 release[i] SHALL be 1 only in the first cycle of IDLE entered from RELEASING.
REQ-022 A stable noisy rise SHALL make debounced rise on the (DEBOUNCE_CYCLES+3)th clk edge after the change; fall latency SHALL be identical.
REQ-023 Any s toggle during ARMING or RELEASING SHALL restart qualification; pulses shorter than DEBOUNCE_CYCLES SHALL produce no output change.
REQ-024 Per channel, a repeat counter rcnt and a first/subsequent phase flag SHALL be cleared on the ARMING->PRESSED transition.
REQ-025 With REPEAT_MASK[i]=1 in PRESSED, rcnt SHALL increment each cycle and SHALL hold its value in RELEASING.
REQ-026 The first repeat pulse SHALL occur REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles, with no drift.
REQ-027 rcnt SHALL clear when each repeat pulse fires.
REQ-028 action[i] SHALL equal press[i] OR repeat pulse[i]; both SHALL never coincide.
REQ-029 With REPEAT_MASK[i]=0, action[i] SHALL equal press[i].
REQ-030 press, release and repeat pulses SHALL never exceed one cycle, and each SHALL be a registered output.

Reset
REQ-031 While reset=1 at a clk edge: all states SHALL go to IDLE, cnt/rcnt/phase/synchronizers SHALL clear, and all outputs SHALL be 0 from the next cycle.
REQ-032 Reset mid-press SHALL produce no release pulse; a still-held button SHALL requalify after reset with full latency and then give a fresh press pulse.

Verification (N=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_PERIOD=3, REPEAT_MASK=2'b01)
REQ-033 noisy[0] 0->1, held -> debounced[0] rises on edge 7; press[0] and action[0] high for that single cycle.
REQ-034 noisy[0] high 3 cycles, then low, repeated 5 times -> debounced, press and action stay 0.
REQ-035 noisy[0] held 20 cycles after press -> action[0] pulses at press+6, +9, +12, +15, +18; noisy[1] held identically -> action[1] only at its press.
REQ-036 While pressed, noisy[0] low 2 cycles, then high -> debounced stays 1; no release pulse; no second press pulse; repeat spacing shifts by exactly 2 cycles.
REQ-037 noisy[0] falls, held low -> debounced falls on edge 7 after the fall; release[0] pulses in that cycle.
REQ-038 reset pulsed 1 cycle while channel 0 is held -> all outputs 0 next cycle, no release pulse; press reappears 7 edges after reset deasserts.

Source files
------------

// File: rtl/debounce_repeat_array.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_repeat_array
//  Function : N independent push-button channels, each with a 2-flop
//             synchronizer, a debounce FSM and an optional auto-repeat
//             generator.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_repeat_array #(
    parameter int             N               = 4,
    parameter int             DEBOUNCE_CYCLES = 1000000,
    parameter int             REPEAT_DELAY    = 30000000,
    parameter int             REPEAT_PERIOD   = 10000000,
    parameter logic [N-1:0]   REPEAT_MASK     = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] noisy,
    output logic [N-1:0] debounced,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] action
);

    localparam int c_MAXP_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int c_MAXP   = (c_MAXP_A > REPEAT_PERIOD) ? c_MAXP_A : REPEAT_PERIOD;
    localparam int c_CW     = $clog2(c_MAXP + 1);

    localparam logic [c_CW-1:0] c_DB_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_RD_LAST = c_CW'(REPEAT_DELAY - 1);
    localparam logic [c_CW-1:0] c_RP_LAST = c_CW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ARMING    = 2'd1;
    localparam logic [1:0] c_PRESSED   = 2'd2;
    localparam logic [1:0] c_RELEASING = 2'd3;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic            r_sync1;
        logic            r_sync2;
        logic [1:0]      r_state;
        logic [1:0]      w_state_nxt;
        logic [c_CW-1:0] r_cnt;
        logic [c_CW-1:0] w_cnt_nxt;
        logic [c_CW-1:0] r_rcnt;
        logic            r_phase;
        logic            r_press;
        logic            r_release;
        logic            r_rep;
        logic            w_press_ev;
        logic            w_release_ev;
        logic            w_rep_run;
        logic            w_rep_hit;

        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_press_ev   = 1'b0;
            w_release_ev = 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (r_sync2) begin
                        w_state_nxt = c_ARMING;
                        w_cnt_nxt   = '0;
                    end
                end
                c_ARMING: begin
                    if (!r_sync2) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        w_state_nxt = c_PRESSED;
                        w_cnt_nxt   = '0;
                        w_press_ev  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                c_PRESSED: begin
                    if (!r_sync2) begin
                        w_state_nxt = c_RELEASING;
                        w_cnt_nxt   = '0;
                    end
                end
                c_RELEASING: begin
                    // A bounce back to 1 resumes the press silently.
                    if (r_sync2) begin
                        w_state_nxt = c_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        w_state_nxt  = c_IDLE;
                        w_cnt_nxt    = '0;
                        w_release_ev = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Repeat timer only runs while PRESSED, so time spent RELEASING shifts it.
        assign w_rep_run = REPEAT_MASK[i] && (r_state == c_PRESSED);
        assign w_rep_hit = w_rep_run && (r_phase ? (r_rcnt == c_RP_LAST)
                                                 : (r_rcnt == c_RD_LAST));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_state   <= c_IDLE;
                r_cnt     <= '0;
                r_rcnt    <= '0;
                r_phase   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_rep     <= 1'b0;
            end else begin
                r_sync1   <= noisy[i];
                r_sync2   <= r_sync1;
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_press   <= w_press_ev;
                r_release <= w_release_ev;
                r_rep     <= w_rep_hit;
                if (w_press_ev) begin
                    r_rcnt  <= '0;
                    r_phase <= 1'b0;
                end else if (w_rep_hit) begin
                    r_rcnt  <= '0;
                    r_phase <= 1'b1;
                end else if (w_rep_run) begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end
        end

        assign debounced[i]     = (r_state == c_PRESSED) || (r_state == c_RELEASING);
        assign press[i]         = r_press;
        assign release_pulse[i] = r_release;
        assign action[i]        = r_press | r_rep;
    end

endmodule
`default_nettype wire
